// File: rtl/rvx_core_fetch_unit.sv
// rvx_core_fetch_unit: instruction fetch stage (s0) of the RVX core.
// Holds the fetch PC and keeps at most one request outstanding on the instruction memory port.
// Delivers {pc, instruction} into the s1 register.
// On a trap or a taken branch, the fetch PC is redirected and any in-flight response is
// discarded. A one-entry skid buffer absorbs a response that arrives while s1 is stalled.
//
// Ports
//   clock, reset                  core clock; synchronous active-high reset
//   take_branch_s1, branch_target_s1   branch/jump redirect from s1 (ignored while stalled)
//   trap_taken, trap_target       trap redirect, highest priority
//   stall_s1                      s1 register must hold
//   imem_address/request/grant    request channel, address stable until granted
//   imem_rvalid/rdata             response channel
//   pc_s1, instruction_s1, instruction_valid_s1   s1 register
module rvx_core_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        take_branch_s1,
  input  logic [31:0] branch_target_s1,
  input  logic        trap_taken,
  input  logic [31:0] trap_target,
  input  logic        stall_s1,
  output logic [31:0] imem_address,
  output logic        imem_request,
  input  logic        imem_grant,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_s1,
  output logic [31:0] instruction_s1,
  output logic        instruction_valid_s1
);

  typedef enum logic [1:0] {StIdle, StRequest, StWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;
  logic [31:0] pc_s1_q, pc_s1_d;
  logic [31:0] instr_s1_q, instr_s1_d;
  logic        valid_s1_q, valid_s1_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_valid_q, skid_valid_d;

  logic        response;
  logic        redirect;
  logic [31:0] target;

  assign response = (state_q == StWait) && imem_rvalid;
  assign redirect = trap_taken || (take_branch_s1 && !stall_s1);
  assign target   = (trap_taken ? trap_target : branch_target_s1) & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    kill_d       = kill_q;
    pc_s1_d      = pc_s1_q;
    instr_s1_d   = instr_s1_q;
    valid_s1_d   = valid_s1_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_valid_d = skid_valid_q;

    // s1 drains by default whenever it is allowed to advance.
    if (!stall_s1) begin
      valid_s1_d = 1'b0;
      instr_s1_d = NOP_INSTRUCTION;
    end

    unique case (state_q)
      StIdle: state_d = StRequest;
      StRequest: begin
        if (imem_grant) state_d = StWait;
      end
      StWait: begin
        if (response) begin
          state_d = StRequest;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (!valid_s1_q || !stall_s1) begin
              pc_s1_d    = fetch_pc_q;
              instr_s1_d = imem_rdata;
              valid_s1_d = 1'b1;
            end else begin
              skid_pc_d    = fetch_pc_q;
              skid_instr_d = imem_rdata;
              skid_valid_d = 1'b1;
              state_d      = StFull;
            end
          end
        end
      end
      StFull: begin
        if (!stall_s1) begin
          pc_s1_d      = skid_pc_q;
          instr_s1_d   = skid_instr_q;
          valid_s1_d   = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = StRequest;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      fetch_pc_d   = target;
      valid_s1_d   = 1'b0;
      instr_s1_d   = NOP_INSTRUCTION;
      skid_valid_d = 1'b0;
      unique case (state_q)
        // The issued (or still pending) request must complete before the target is fetched.
        StRequest: kill_d = 1'b1;
        // A response in this same cycle closes the old request; otherwise it must be killed.
        StWait: begin
          if (response) begin
            kill_d  = 1'b0;
            state_d = StRequest;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: begin
          kill_d  = 1'b0;
          state_d = StRequest;
        end
      endcase
    end

    // The address tracks the fetch PC except while an ungranted request is on the bus.
    if (!(state_q == StRequest && !imem_grant)) req_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= BOOT_ADDRESS;
      req_addr_q   <= BOOT_ADDRESS;
      kill_q       <= 1'b0;
      pc_s1_q      <= BOOT_ADDRESS;
      instr_s1_q   <= NOP_INSTRUCTION;
      valid_s1_q   <= 1'b0;
      skid_pc_q    <= BOOT_ADDRESS;
      skid_instr_q <= NOP_INSTRUCTION;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      kill_q       <= kill_d;
      pc_s1_q      <= pc_s1_d;
      instr_s1_q   <= instr_s1_d;
      valid_s1_q   <= valid_s1_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign imem_request         = (state_q == StRequest);
  assign imem_address         = req_addr_q;
  assign pc_s1                = pc_s1_q;
  assign instruction_s1       = instr_s1_q;
  assign instruction_valid_s1 = valid_s1_q;

endmodule

// File: tb/tb_rvx_core_fetch_unit.sv
module tb_rvx_core_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        take_branch_s1;
  logic [31:0] branch_target_s1;
  logic        trap_taken;
  logic [31:0] trap_target;
  logic        stall_s1;
  logic [31:0] imem_address;
  logic        imem_request;
  logic        imem_grant;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_s1;
  logic [31:0] instruction_s1;
  logic        instruction_valid_s1;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  rvx_core_fetch_unit dut (
    .clock               (clock),
    .reset               (reset),
    .take_branch_s1      (take_branch_s1),
    .branch_target_s1    (branch_target_s1),
    .trap_taken          (trap_taken),
    .trap_target         (trap_target),
    .stall_s1            (stall_s1),
    .imem_address        (imem_address),
    .imem_request        (imem_request),
    .imem_grant          (imem_grant),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .pc_s1               (pc_s1),
    .instruction_s1      (instruction_s1),
    .instruction_valid_s1(instruction_valid_s1)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    take_branch_s1 = 1'b0;
    branch_target_s1 = '0;
    trap_taken = 1'b0;
    trap_target = '0;
    stall_s1 = 1'b0;
    imem_grant = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    tick();
    tick();
    check_value("rst_req", {31'd0, imem_request}, 32'd0);
    check_value("rst_addr", imem_address, 32'h0);
    check_value("rst_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("rst_instr", instruction_s1, Nop);
    check_value("rst_pc", pc_s1, 32'h0);

    // Late rvalid in the IDLE cycle after reset is ignored.
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_value("late_rvalid_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("first_req", {31'd0, imem_request}, 32'd1);
    check_value("first_addr", imem_address, 32'h0);

    // Test 1: streaming, one instruction per two cycles.
    imem_grant = 1'b1;
    tick();
    check_value("t1_wait_req", {31'd0, imem_request}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_0000;
    tick();
    imem_rvalid = 1'b0;
    check_value("t1_pc0", pc_s1, 32'h0);
    check_value("t1_instr0", instruction_s1, 32'h1111_0000);
    check_value("t1_valid0", {31'd0, instruction_valid_s1}, 32'd1);
    check_value("t1_addr4", imem_address, 32'h4);
    check_value("t1_req4", {31'd0, imem_request}, 32'd1);
    tick();
    check_value("t1_bubble_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("t1_bubble_instr", instruction_s1, Nop);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_0004;
    tick();
    imem_rvalid = 1'b0;
    check_value("t1_pc4", pc_s1, 32'h4);
    check_value("t1_addr8", imem_address, 32'h8);

    // Test 2: stall during response at 0x8 fills the skid buffer.
    stall_s1 = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_0008;
    tick();
    imem_rvalid = 1'b0;
    check_value("t2_pc_hold", pc_s1, 32'h4);
    check_value("t2_valid_hold", {31'd0, instruction_valid_s1}, 32'd1);
    check_value("t2_no_req", {31'd0, imem_request}, 32'd0);
    tick();
    check_value("t2_no_req2", {31'd0, imem_request}, 32'd0);
    check_value("t2_pc_hold2", pc_s1, 32'h4);
    stall_s1 = 1'b0;
    tick();
    check_value("t2_pc8", pc_s1, 32'h8);
    check_value("t2_instr8", instruction_s1, 32'h1111_0008);
    check_value("t2_reqC", {31'd0, imem_request}, 32'd1);
    check_value("t2_addrC", imem_address, 32'hC);

    // Test 3: branch while 0x10 is in WAIT kills its response.
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_000C;
    tick();
    imem_rvalid = 1'b0;
    check_value("t3_pcC", pc_s1, 32'hC);
    check_value("t3_addr10", imem_address, 32'h10);
    tick();
    take_branch_s1 = 1'b1;
    branch_target_s1 = 32'h0000_0103;
    tick();
    take_branch_s1 = 1'b0;
    check_value("t3_valid_flush", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("t3_no_req", {31'd0, imem_request}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0010;
    tick();
    imem_rvalid = 1'b0;
    check_value("t3_killed_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("t3_killed_instr", instruction_s1, Nop);
    check_value("t3_req", {31'd0, imem_request}, 32'd1);
    check_value("t3_addr100", imem_address, 32'h100);

    // Test 4: trap and branch together, trap wins (redirect at granted REQUEST).
    trap_taken = 1'b1;
    trap_target = 32'h0000_0080;
    take_branch_s1 = 1'b1;
    branch_target_s1 = 32'h0000_0200;
    tick();
    trap_taken = 1'b0;
    take_branch_s1 = 1'b0;
    check_value("t4_no_req", {31'd0, imem_request}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0100;
    tick();
    imem_rvalid = 1'b0;
    check_value("t4_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("t4_addr80", imem_address, 32'h80);
    check_value("t4_req", {31'd0, imem_request}, 32'd1);

    // Test 5: ungranted request holds its address through a branch.
    imem_grant = 1'b0;
    tick();
    check_value("t5_addr_c1", imem_address, 32'h80);
    take_branch_s1 = 1'b1;
    branch_target_s1 = 32'h0000_0300;
    tick();
    take_branch_s1 = 1'b0;
    check_value("t5_addr_c2", imem_address, 32'h80);
    check_value("t5_req_c2", {31'd0, imem_request}, 32'd1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check_value("t5_addr_hold", imem_address, 32'h80);
    end
    imem_grant = 1'b1;
    tick();
    check_value("t5_granted", {31'd0, imem_request}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0080;
    tick();
    imem_rvalid = 1'b0;
    check_value("t5_killed_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("t5_addr300", imem_address, 32'h300);

    // Test 6: wrap from 0xFFFFFFFC to 0; target low bits are masked.
    take_branch_s1 = 1'b1;
    branch_target_s1 = 32'hFFFF_FFFF;
    tick();
    take_branch_s1 = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0300;
    tick();
    imem_rvalid = 1'b0;
    check_value("t6_addr_top", imem_address, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h2222_FFFC;
    tick();
    imem_rvalid = 1'b0;
    check_value("t6_pc_top", pc_s1, 32'hFFFF_FFFC);
    check_value("t6_instr_top", instruction_s1, 32'h2222_FFFC);
    check_value("t6_addr_wrap", imem_address, 32'h0);

    // Redirect and rvalid in the same cycle: response dropped, target fetched next.
    tick();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    take_branch_s1 = 1'b1;
    branch_target_s1 = 32'h0000_0400;
    tick();
    imem_rvalid = 1'b0;
    take_branch_s1 = 1'b0;
    check_value("same_cycle_valid", {31'd0, instruction_valid_s1}, 32'd0);
    check_value("same_cycle_req", {31'd0, imem_request}, 32'd1);
    check_value("same_cycle_addr", imem_address, 32'h400);

    // Reset mid-transaction drops everything.
    tick();
    reset = 1'b1;
    tick();
    check_value("mid_rst_req", {31'd0, imem_request}, 32'd0);
    check_value("mid_rst_addr", imem_address, 32'h0);
    check_value("mid_rst_pc", pc_s1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
